// File: rtl/common_pkg.sv
`default_nettype none
// ============================================================================
// Module      : common_pkg
// Description : Shared data word type and architectural register numbers
//               used across the vector datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package common_pkg;

  typedef logic [31:0] data_t;

  // Fixed register numbers; everything up to BLOCK_SIZE_REG is read-only.
  localparam int ZERO_REG       = 0;
  localparam int THREAD_ID_REG  = 1;
  localparam int BLOCK_ID_REG   = 2;
  localparam int BLOCK_SIZE_REG = 3;

endpackage
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : reg_scoreboard
// Description : One pending bit per (warp, register). Reservations set a bit,
//               writebacks clear it, context init clears a whole warp.
//               Two combinational lookups report pending state for operands.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_scoreboard #(
  parameter int NUM_WARPS       = 4,
  parameter int REGS_PER_THREAD = 32,
  parameter int WB              = 2,
  parameter int RB              = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          set_valid,
  input  logic [WB-1:0] set_warp,
  input  logic [RB-1:0] set_addr,
  input  logic          clr_valid,
  input  logic [WB-1:0] clr_warp,
  input  logic [RB-1:0] clr_addr,
  input  logic          warp_clr_valid,
  input  logic [WB-1:0] warp_clr_warp,
  input  logic [WB-1:0] lookup_warp,
  input  logic [RB-1:0] lookup_addr_a,
  input  logic [RB-1:0] lookup_addr_b,
  output logic          pending_a,
  output logic          pending_b
);

  logic [REGS_PER_THREAD-1:0] r_pending [NUM_WARPS];

  logic w_clr_hits_a;
  logic w_clr_hits_b;

  // Pending-bit update: warp clear beats set, and set beats clear because it
  // is applied last.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        r_pending[w] <= '0;
      end
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (warp_clr_valid && warp_clr_warp == WB'(w)) begin
          r_pending[w] <= '0;
        end else begin
          if (clr_valid && clr_warp == WB'(w)) begin
            r_pending[w][clr_addr] <= 1'b0;
          end
          if (set_valid && set_warp == WB'(w)) begin
            r_pending[w][set_addr] <= 1'b1;
          end
        end
      end
    end
  end

  // A bit being cleared by a writeback this cycle already counts as free.
  assign w_clr_hits_a = clr_valid && clr_warp == lookup_warp && clr_addr == lookup_addr_a;
  assign w_clr_hits_b = clr_valid && clr_warp == lookup_warp && clr_addr == lookup_addr_b;

  assign pending_a = r_pending[lookup_warp][lookup_addr_a] && !w_clr_hits_a;
  assign pending_b = r_pending[lookup_warp][lookup_addr_b] && !w_clr_hits_b;

endmodule
`default_nettype wire

// File: rtl/vec_regfile.sv
`default_nettype none
// ============================================================================
// Module      : vec_regfile
// Description : Per-warp, per-lane vector register file with hardwired zero
//               and context registers, destination scoreboard, write
//               forwarding and a one-cycle registered operand response.
// Revision    : 1.0 - initial release
// ============================================================================
module vec_regfile
  import common_pkg::*;
#(
  parameter int THREADS_PER_WARP = 4,
  parameter int REGS_PER_THREAD  = 32,
  parameter int NUM_WARPS        = 4,
  parameter int WB               = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  parameter int RB               = $clog2(REGS_PER_THREAD)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               init_valid,
  input  logic [WB-1:0]                      init_warp,
  input  logic [31:0]                        init_warp_id,
  input  logic [31:0]                        init_block_id,
  input  logic [31:0]                        init_block_size,
  input  logic                               rd_req_valid,
  output logic                               rd_req_ready,
  input  logic [WB-1:0]                      rd_warp,
  input  logic [RB-1:0]                      rs1_addr,
  input  logic [RB-1:0]                      rs2_addr,
  input  logic [THREADS_PER_WARP-1:0]        rd_thread_mask,
  output logic                               rd_resp_valid,
  output data_t [THREADS_PER_WARP-1:0]       rs1_data,
  output data_t [THREADS_PER_WARP-1:0]       rs2_data,
  input  logic                               rsv_valid,
  input  logic [WB-1:0]                      rsv_warp,
  input  logic [RB-1:0]                      rsv_addr,
  input  logic                               wr_valid,
  input  logic [WB-1:0]                      wr_warp,
  input  logic [RB-1:0]                      wr_addr,
  input  logic [THREADS_PER_WARP-1:0]        wr_thread_mask,
  input  data_t [THREADS_PER_WARP-1:0]       wr_data
);

  localparam logic [RB-1:0] C_LAST_RO_REG = RB'(BLOCK_SIZE_REG);

  data_t r_mem [NUM_WARPS][THREADS_PER_WARP][REGS_PER_THREAD];

  logic                         w_rsv_ok;
  logic                         w_wr_ok;
  logic                         w_pend1;
  logic                         w_pend2;
  logic                         w_accept;
  logic                         w_fwd1;
  logic                         w_fwd2;
  data_t [THREADS_PER_WARP-1:0] w_rs1_lane;
  data_t [THREADS_PER_WARP-1:0] w_rs2_lane;

  // Registers 0..3 are never written and never reserved.
  assign w_rsv_ok = rsv_valid && rsv_addr > C_LAST_RO_REG;
  assign w_wr_ok  = wr_valid  && wr_addr  > C_LAST_RO_REG;

  reg_scoreboard #(
    .NUM_WARPS       (NUM_WARPS),
    .REGS_PER_THREAD (REGS_PER_THREAD),
    .WB              (WB),
    .RB              (RB)
  ) u_scoreboard (
    .clk            (clk),
    .reset          (reset),
    .set_valid      (w_rsv_ok),
    .set_warp       (rsv_warp),
    .set_addr       (rsv_addr),
    .clr_valid      (w_wr_ok),
    .clr_warp       (wr_warp),
    .clr_addr       (wr_addr),
    .warp_clr_valid (init_valid),
    .warp_clr_warp  (init_warp),
    .lookup_warp    (rd_warp),
    .lookup_addr_a  (rs1_addr),
    .lookup_addr_b  (rs2_addr),
    .pending_a      (w_pend1),
    .pending_b      (w_pend2)
  );

  assign rd_req_ready = reset || !(w_pend1 || w_pend2);
  assign w_accept     = rd_req_valid && rd_req_ready;

  assign w_fwd1 = w_wr_ok && wr_warp == rd_warp && wr_addr == rs1_addr;
  assign w_fwd2 = w_wr_ok && wr_warp == rd_warp && wr_addr == rs2_addr;

  // Per-lane operand select: masked lane -> 0, reg 0 -> 0, forwarded write
  // data when this lane is written this cycle, else stored value.
  for (genvar t = 0; t < THREADS_PER_WARP; t++) begin : g_lane
    assign w_rs1_lane[t] = (!rd_thread_mask[t] || rs1_addr == RB'(ZERO_REG)) ? '0 :
                           (w_fwd1 && wr_thread_mask[t]) ? wr_data[t] :
                           r_mem[rd_warp][t][rs1_addr];
    assign w_rs2_lane[t] = (!rd_thread_mask[t] || rs2_addr == RB'(ZERO_REG)) ? '0 :
                           (w_fwd2 && wr_thread_mask[t]) ? wr_data[t] :
                           r_mem[rd_warp][t][rs2_addr];
  end

  // Register storage: context init loads regs 1..3, writeback updates
  // masked lanes of regs 4 and up.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        for (int t = 0; t < THREADS_PER_WARP; t++) begin
          for (int r = 0; r < REGS_PER_THREAD; r++) begin
            r_mem[w][t][r] <= '0;
          end
        end
      end
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        for (int t = 0; t < THREADS_PER_WARP; t++) begin
          if (init_valid && init_warp == WB'(w)) begin
            r_mem[w][t][THREAD_ID_REG]  <= init_warp_id * 32'(THREADS_PER_WARP) + 32'(t);
            r_mem[w][t][BLOCK_ID_REG]   <= init_block_id;
            r_mem[w][t][BLOCK_SIZE_REG] <= init_block_size;
          end
          if (w_wr_ok && wr_warp == WB'(w) && wr_thread_mask[t]) begin
            r_mem[w][t][wr_addr] <= wr_data[t];
          end
        end
      end
    end
  end

  // Operand response: one-cycle pulse, data held between responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_resp_valid <= 1'b0;
      rs1_data      <= '0;
      rs2_data      <= '0;
    end else begin
      rd_resp_valid <= w_accept;
      if (w_accept) begin
        rs1_data <= w_rs1_lane;
        rs2_data <= w_rs2_lane;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vec_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_vec_regfile
// Description : Directed self-checking bench for vec_regfile (T=4, R=32, W=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vec_regfile;
  import common_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  logic          init_valid;
  logic [1:0]    init_warp;
  logic [31:0]   init_warp_id;
  logic [31:0]   init_block_id;
  logic [31:0]   init_block_size;
  logic          rd_req_valid;
  logic          rd_req_ready;
  logic [1:0]    rd_warp;
  logic [4:0]    rs1_addr;
  logic [4:0]    rs2_addr;
  logic [3:0]    rd_thread_mask;
  logic          rd_resp_valid;
  data_t [3:0]   rs1_data;
  data_t [3:0]   rs2_data;
  logic          rsv_valid;
  logic [1:0]    rsv_warp;
  logic [4:0]    rsv_addr;
  logic          wr_valid;
  logic [1:0]    wr_warp;
  logic [4:0]    wr_addr;
  logic [3:0]    wr_thread_mask;
  data_t [3:0]   wr_data;

  int total = 0;
  int bad   = 0;

  vec_regfile #(
    .THREADS_PER_WARP (4),
    .REGS_PER_THREAD  (32),
    .NUM_WARPS        (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .init_valid      (init_valid),
    .init_warp       (init_warp),
    .init_warp_id    (init_warp_id),
    .init_block_id   (init_block_id),
    .init_block_size (init_block_size),
    .rd_req_valid    (rd_req_valid),
    .rd_req_ready    (rd_req_ready),
    .rd_warp         (rd_warp),
    .rs1_addr        (rs1_addr),
    .rs2_addr        (rs2_addr),
    .rd_thread_mask  (rd_thread_mask),
    .rd_resp_valid   (rd_resp_valid),
    .rs1_data        (rs1_data),
    .rs2_data        (rs2_data),
    .rsv_valid       (rsv_valid),
    .rsv_warp        (rsv_warp),
    .rsv_addr        (rsv_addr),
    .wr_valid        (wr_valid),
    .wr_warp         (wr_warp),
    .wr_addr         (wr_addr),
    .wr_thread_mask  (wr_thread_mask),
    .wr_data         (wr_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    init_valid = 0; init_warp = 0; init_warp_id = 0; init_block_id = 0; init_block_size = 0;
    rd_req_valid = 0; rd_warp = 0; rs1_addr = 0; rs2_addr = 0; rd_thread_mask = 4'hF;
    rsv_valid = 0; rsv_warp = 0; rsv_addr = 0;
    wr_valid = 0; wr_warp = 0; wr_addr = 0; wr_thread_mask = 0; wr_data = '0;
  endtask

  task automatic read(input logic [1:0] w, input logic [4:0] a1, input logic [4:0] a2,
                      input logic [3:0] m);
    rd_req_valid = 1; rd_warp = w; rs1_addr = a1; rs2_addr = a2; rd_thread_mask = m;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    reset = 1;
    #1;
    chk("ready_in_reset", 128'(rd_req_ready), 128'(1));
    tick(); tick();
    chk("reset_valid", 128'(rd_resp_valid), 128'(0));
    chk("reset_rs1", rs1_data, 128'(0));
    chk("reset_rs2", rs2_data, 128'(0));
    reset = 0;
    #1;
    chk("ready_after_reset", 128'(rd_req_ready), 128'(1));

    // Context init of warp 2, then read thread id and block size.
    tick();
    init_valid = 1; init_warp = 2; init_warp_id = 5; init_block_id = 7; init_block_size = 64;
    tick();
    idle();
    read(2, 1, 3, 4'hF);
    #1;
    chk("init_read_ready", 128'(rd_req_ready), 128'(1));
    tick();
    idle();
    chk("init_resp_valid", 128'(rd_resp_valid), 128'(1));
    chk("init_rs1_tid", rs1_data, {32'd23, 32'd22, 32'd21, 32'd20});
    chk("init_rs2_bsize", rs2_data, {32'd64, 32'd64, 32'd64, 32'd64});
    tick();
    chk("resp_pulse_low", 128'(rd_resp_valid), 128'(0));
    chk("resp_hold_rs1", rs1_data, {32'd23, 32'd22, 32'd21, 32'd20});

    // Partial read mask zeroes disabled lanes.
    read(2, 1, 2, 4'b0011);
    tick();
    idle();
    chk("mask_rs1", rs1_data, {32'd0, 32'd0, 32'd21, 32'd20});
    chk("mask_rs2", rs2_data, {32'd0, 32'd0, 32'd7, 32'd7});

    // Masked write to warp 0 reg 9.
    wr_valid = 1; wr_warp = 0; wr_addr = 9; wr_thread_mask = 4'b0101;
    wr_data = {32'hDEAD, 32'hDEAD, 32'hDEAD, 32'hDEAD};
    tick();
    idle();
    read(0, 9, 2, 4'hF);
    tick();
    idle();
    chk("wmask_rs1", rs1_data, {32'd0, 32'hDEAD, 32'd0, 32'hDEAD});
    chk("wmask_rs2", rs2_data, 128'(0));

    // Reservation stalls the read; a same-cycle writeback releases and forwards.
    rsv_valid = 1; rsv_warp = 1; rsv_addr = 12;
    tick();
    idle();
    read(1, 12, 0, 4'hF);
    #1;
    chk("rsv_ready_low", 128'(rd_req_ready), 128'(0));
    tick();
    chk("stall_no_resp", 128'(rd_resp_valid), 128'(0));
    wr_valid = 1; wr_warp = 1; wr_addr = 12; wr_thread_mask = 4'hF;
    wr_data = {32'h55, 32'h55, 32'h55, 32'h55};
    #1;
    chk("wr_release_ready", 128'(rd_req_ready), 128'(1));
    tick();
    idle();
    chk("fwd_valid", 128'(rd_resp_valid), 128'(1));
    chk("fwd_rs1", rs1_data, {32'h55, 32'h55, 32'h55, 32'h55});
    read(1, 12, 12, 4'hF);
    #1;
    chk("cleared_ready", 128'(rd_req_ready), 128'(1));
    tick();
    idle();
    chk("stored_rs2", rs2_data, {32'h55, 32'h55, 32'h55, 32'h55});

    // Set wins over a same-cycle clear.
    rsv_valid = 1; rsv_warp = 1; rsv_addr = 13;
    wr_valid = 1; wr_warp = 1; wr_addr = 13; wr_thread_mask = 4'hF;
    wr_data = {32'h77, 32'h77, 32'h77, 32'h77};
    tick();
    idle();
    read(1, 13, 0, 4'hF);
    #1;
    chk("set_wins_ready", 128'(rd_req_ready), 128'(0));
    rd_req_valid = 0;
    // Init beats a same-cycle reservation and clears the warp's bits.
    init_valid = 1; init_warp = 1;
    rsv_valid = 1; rsv_warp = 1; rsv_addr = 14;
    tick();
    idle();
    read(1, 13, 14, 4'hF);
    #1;
    chk("init_wins_ready", 128'(rd_req_ready), 128'(1));
    tick();
    idle();
    chk("after_init_rs1", rs1_data, {32'h77, 32'h77, 32'h77, 32'h77});

    // Writes and reservations to read-only registers are ignored.
    wr_valid = 1; wr_warp = 2; wr_addr = 0; wr_thread_mask = 4'hF;
    wr_data = {32'hFFFF, 32'hFFFF, 32'hFFFF, 32'hFFFF};
    tick();
    wr_addr = 2;
    rsv_valid = 1; rsv_warp = 2; rsv_addr = 2;
    tick();
    idle();
    read(2, 0, 2, 4'hF);
    #1;
    chk("ro_rsv_ready", 128'(rd_req_ready), 128'(1));
    tick();
    idle();
    chk("ro_reg0", rs1_data, 128'(0));
    chk("ro_reg2", rs2_data, {32'd7, 32'd7, 32'd7, 32'd7});

    // No forwarding from init: same-cycle read sees pre-init values.
    init_valid = 1; init_warp = 3; init_warp_id = 1; init_block_id = 9; init_block_size = 32;
    read(3, 1, 2, 4'hF);
    tick();
    idle();
    chk("init_nofwd_rs1", rs1_data, 128'(0));
    chk("init_nofwd_rs2", rs2_data, 128'(0));
    read(3, 1, 2, 4'hF);
    tick();
    idle();
    chk("init3_rs1", rs1_data, {32'd7, 32'd6, 32'd5, 32'd4});
    chk("init3_rs2", rs2_data, {32'd9, 32'd9, 32'd9, 32'd9});

    // Reset in the acceptance cycle drops the response and clears storage.
    read(2, 1, 3, 4'hF);
    reset = 1;
    tick();
    chk("rst_drop_valid", 128'(rd_resp_valid), 128'(0));
    chk("rst_drop_rs1", rs1_data, 128'(0));
    chk("rst_drop_rs2", rs2_data, 128'(0));
    reset = 0;
    idle();
    tick();
    chk("rst_still_invalid", 128'(rd_resp_valid), 128'(0));
    read(2, 1, 3, 4'hF);
    tick();
    idle();
    chk("post_rst_valid", 128'(rd_resp_valid), 128'(1));
    chk("post_rst_rs1", rs1_data, 128'(0));
    chk("post_rst_rs2", rs2_data, 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
